// File: rtl/chip8_pkg.sv
// chip8_pkg: controller states, opcode classes, Fx sub-op codes and shared helpers
// for the CHIP-8 execution core.
package chip8_pkg;

  // Controller states; memory states raise mem_req one cycle after entry.
  typedef enum logic [2:0] {
    S_FETCH_HI,
    S_FETCH_LO,
    S_EXEC,
    S_BCD,
    S_STORE,
    S_LOAD,
    S_HALT
  } state_e;

  // Opcode class = top nibble of the instruction word.
  localparam logic [3:0] OP_SYS  = 4'h0;
  localparam logic [3:0] OP_JP   = 4'h1;
  localparam logic [3:0] OP_CALL = 4'h2;
  localparam logic [3:0] OP_SE   = 4'h3;
  localparam logic [3:0] OP_SNE  = 4'h4;
  localparam logic [3:0] OP_SEV  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ADD  = 4'h7;
  localparam logic [3:0] OP_ALU  = 4'h8;
  localparam logic [3:0] OP_SNEV = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_JPV0 = 4'hB;
  localparam logic [3:0] OP_RND  = 4'hC;
  localparam logic [3:0] OP_DRW  = 4'hD;
  localparam logic [3:0] OP_SKP  = 4'hE;
  localparam logic [3:0] OP_F    = 4'hF;

  // Fx sub-operations (low byte of the instruction).
  localparam logic [7:0] FX_LD_VX_DT = 8'h07;
  localparam logic [7:0] FX_LD_VX_K  = 8'h0A;
  localparam logic [7:0] FX_LD_DT    = 8'h15;
  localparam logic [7:0] FX_LD_ST    = 8'h18;
  localparam logic [7:0] FX_ADD_I    = 8'h1E;
  localparam logic [7:0] FX_LD_F     = 8'h29;
  localparam logic [7:0] FX_BCD      = 8'h33;
  localparam logic [7:0] FX_STORE    = 8'h55;
  localparam logic [7:0] FX_LOAD     = 8'h65;

  // Hex font glyphs (5 bytes each) start here.
  localparam int unsigned FONT_BASE = 0;

  // Decimal digit of val: pos 0 = hundreds, 1 = tens, 2 = ones.
  function automatic logic [7:0] bcd_digit(input logic [7:0] val, input logic [1:0] pos);
    logic [7:0] d;
    case (pos)
      2'd0:    d = val / 8'd100;
      2'd1:    d = (val / 8'd10) % 8'd10;
      default: d = val % 8'd10;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/chip8_timers.sv
// chip8_timers: tick divider plus the delay and sound timers. A direct load
// beats a decrement landing in the same cycle; sound is on while ST != 0.
module chip8_timers #(
  parameter int TICK_DIV = 400000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dt_we_i,
  input  logic       st_we_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] dt_o,
  output logic       sound_on_o
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       dt_q;
  logic [7:0]       st_q;
  logic             tick;

  assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

  // Free-running divider, wraps to zero on the tick cycle.
  always_ff @(posedge clk) begin
    if (reset)     cnt_q <= '0;
    else if (tick) cnt_q <= '0;
    else           cnt_q <= cnt_q + CNT_W'(1);
  end

  // Delay timer: load wins, otherwise count down on ticks until zero.
  always_ff @(posedge clk) begin
    if (reset)                      dt_q <= 8'h00;
    else if (dt_we_i)               dt_q <= wdata_i;
    else if (tick && dt_q != 8'h00) dt_q <= dt_q - 8'd1;
  end

  // Sound timer: same policy as the delay timer.
  always_ff @(posedge clk) begin
    if (reset)                      st_q <= 8'h00;
    else if (st_we_i)               st_q <= wdata_i;
    else if (tick && st_q != 8'h00) st_q <= st_q - 8'd1;
  end

  assign dt_o       = dt_q;
  assign sound_on_o = (st_q != 8'h00);

endmodule

// File: rtl/chip8_core.sv
// chip8_core: CHIP-8 fetch/decode/execute core with a req/ack byte memory port,
// internal return stack and 60 Hz timers. Display/keypad opcodes retire as NOPs.
// Build option: define CHIP8_RNG_EN to make Cxkk use a free-running 16-bit LFSR;
// without it Cxkk loads kk unchanged so regressions stay deterministic.
module chip8_core
  import chip8_pkg::*;
#(
  parameter int          ADDR_W      = 12,
  parameter int          STACK_DEPTH = 16,
  parameter int unsigned RESET_PC    = 'h200,
  parameter int          TICK_DIV    = 400000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              halted,
  output logic              fault,
  output logic              sound_on,
  output logic [ADDR_W-1:0] debug_pc
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 2) ? $clog2(STACK_DEPTH) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [7:0]        op_hi_q, op_hi_d;
  logic [7:0]        op_lo_q, op_lo_d;
  logic [7:0]        vx_q, vx_d;
  logic [7:0]        vy_q, vy_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              fault_q, fault_d;

  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic              stack_we;
  logic [ADDR_W-1:0] stack_wdata;
  logic [IDX_W-1:0]  sp_idx, sp_top;

  logic [7:0]        v_rf [16];
  logic              v_we;
  logic [3:0]        v_widx;
  logic [7:0]        v_wdata;
  logic              vf_we;
  logic [7:0]        vf_wdata;

  logic              dt_we, st_we;
  logic [7:0]        dt_val;
  logic [7:0]        rnd_byte;

  logic [3:0]        op_cls, op_x, op_n;
  logic [7:0]        op_kk;
  logic [ADDR_W-1:0] op_nnn;
  logic [ADDR_W-1:0] pc_plus2, pc_plus4;
  logic [8:0]        sum9;

  assign op_cls   = op_hi_q[7:4];
  assign op_x     = op_hi_q[3:0];
  assign op_n     = op_lo_q[3:0];
  assign op_kk    = op_lo_q;
  assign op_nnn   = ADDR_W'({op_hi_q[3:0], op_lo_q});
  assign pc_plus2 = pc_q + ADDR_W'(2);
  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign sum9     = {1'b0, vx_q} + {1'b0, vy_q};
  assign sp_idx   = IDX_W'(sp_q);
  assign sp_top   = IDX_W'(sp_q - SP_W'(1));

`ifdef CHIP8_RNG_EN
  logic [15:0] lfsr_q;

  // Galois LFSR, taps 16/14/13/11, advances every clock.
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  assign rnd_byte = lfsr_q[7:0];
`else
  assign rnd_byte = 8'hFF;
`endif

  // Controller state and architectural registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH_HI;
      pc_q    <= ADDR_W'(RESET_PC);
      i_q     <= '0;
      sp_q    <= '0;
      op_hi_q <= 8'h00;
      op_lo_q <= 8'h00;
      vx_q    <= 8'h00;
      vy_q    <= 8'h00;
      cnt_q   <= 4'h0;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      i_q     <= i_d;
      sp_q    <= sp_d;
      op_hi_q <= op_hi_d;
      op_lo_q <= op_lo_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      fault_q <= fault_d;
    end
  end

  // Return stack storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (stack_we) stack_q[sp_idx] <= stack_wdata;
  end

  // V0..VF: the flag write is applied last so it wins when x == F.
  for (genvar gi = 0; gi < 16; gi++) begin : g_vreg
    logic [7:0] v_q;
    always_ff @(posedge clk) begin
      if (reset)                             v_q <= 8'h00;
      else if (vf_we && gi == 15)            v_q <= vf_wdata;
      else if (v_we && v_widx == 4'(gi))     v_q <= v_wdata;
    end
    assign v_rf[gi] = v_q;
  end

  // Next-state, handshake and instruction execution.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    i_d         = i_q;
    sp_d        = sp_q;
    op_hi_d     = op_hi_q;
    op_lo_d     = op_lo_q;
    vx_d        = vx_q;
    vy_d        = vy_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    fault_d     = fault_q;
    stack_we    = 1'b0;
    stack_wdata = pc_plus2;
    v_we        = 1'b0;
    v_widx      = op_x;
    v_wdata     = 8'h00;
    vf_we       = 1'b0;
    vf_wdata    = 8'h00;
    dt_we       = 1'b0;
    st_we       = 1'b0;

    unique case (state_q)
      S_FETCH_HI: begin
        if (!req_q) req_d = 1'b1;
        else if (mem_ack) begin
          req_d   = 1'b0;
          op_hi_d = mem_rdata;
          state_d = S_FETCH_LO;
        end
      end

      S_FETCH_LO: begin
        if (!req_q) req_d = 1'b1;
        else if (mem_ack) begin
          req_d   = 1'b0;
          op_lo_d = mem_rdata;
          vx_d    = v_rf[op_x];
          vy_d    = v_rf[mem_rdata[7:4]];
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_FETCH_HI;
        pc_d    = pc_plus2;
        cnt_d   = 4'h0;
        case (op_cls)
          OP_SYS: begin
            if (op_x == 4'h0 && op_kk == 8'hEE) begin
              if (sp_q == '0) begin
                fault_d = 1'b1;
                state_d = S_HALT;
                pc_d    = pc_q;
              end else begin
                sp_d = sp_q - SP_W'(1);
                pc_d = stack_q[sp_top];
              end
            end else if (op_x == 4'h0 && op_kk == 8'hFD) begin
              state_d = S_HALT;
              pc_d    = pc_q;
            end
          end
          OP_JP: pc_d = op_nnn;
          OP_CALL: begin
            if (sp_q == SP_W'(STACK_DEPTH)) begin
              fault_d = 1'b1;
              state_d = S_HALT;
              pc_d    = pc_q;
            end else begin
              stack_we = 1'b1;
              sp_d     = sp_q + SP_W'(1);
              pc_d     = op_nnn;
            end
          end
          OP_SE:   if (vx_q == op_kk) pc_d = pc_plus4;
          OP_SNE:  if (vx_q != op_kk) pc_d = pc_plus4;
          OP_SEV:  if (op_n == 4'h0 && vx_q == vy_q) pc_d = pc_plus4;
          OP_SNEV: if (op_n == 4'h0 && vx_q != vy_q) pc_d = pc_plus4;
          OP_LD: begin
            v_we    = 1'b1;
            v_wdata = op_kk;
          end
          OP_ADD: begin
            v_we    = 1'b1;
            v_wdata = vx_q + op_kk;
          end
          OP_ALU: begin
            case (op_n)
              4'h0: begin v_we = 1'b1; v_wdata = vy_q; end
              4'h1: begin v_we = 1'b1; v_wdata = vx_q | vy_q; end
              4'h2: begin v_we = 1'b1; v_wdata = vx_q & vy_q; end
              4'h3: begin v_we = 1'b1; v_wdata = vx_q ^ vy_q; end
              4'h4: begin
                v_we = 1'b1; v_wdata = sum9[7:0];
                vf_we = 1'b1; vf_wdata = {7'b0, sum9[8]};
              end
              4'h5: begin
                v_we = 1'b1; v_wdata = vx_q - vy_q;
                vf_we = 1'b1; vf_wdata = {7'b0, vx_q >= vy_q};
              end
              4'h6: begin
                v_we = 1'b1; v_wdata = {1'b0, vx_q[7:1]};
                vf_we = 1'b1; vf_wdata = {7'b0, vx_q[0]};
              end
              4'h7: begin
                v_we = 1'b1; v_wdata = vy_q - vx_q;
                vf_we = 1'b1; vf_wdata = {7'b0, vy_q >= vx_q};
              end
              4'hE: begin
                v_we = 1'b1; v_wdata = {vx_q[6:0], 1'b0};
                vf_we = 1'b1; vf_wdata = {7'b0, vx_q[7]};
              end
              default: ;
            endcase
          end
          OP_LDI:  i_d  = op_nnn;
          OP_JPV0: pc_d = op_nnn + ADDR_W'(v_rf[0]);
          OP_RND: begin
            v_we    = 1'b1;
            v_wdata = rnd_byte & op_kk;
          end
          OP_DRW, OP_SKP: ;
          OP_F: begin
            case (op_kk)
              FX_LD_VX_DT: begin v_we = 1'b1; v_wdata = dt_val; end
              FX_LD_VX_K:  ;
              FX_LD_DT:    dt_we = 1'b1;
              FX_LD_ST:    st_we = 1'b1;
              FX_ADD_I:    i_d = i_q + ADDR_W'(vx_q);
              FX_LD_F:     i_d = ADDR_W'(FONT_BASE) + ADDR_W'({vx_q[3:0], 2'b00})
                                 + ADDR_W'(vx_q[3:0]);
              FX_BCD:      state_d = S_BCD;
              FX_STORE:    state_d = S_STORE;
              FX_LOAD:     state_d = S_LOAD;
              default:     ;
            endcase
          end
          default: ;
        endcase
      end

      S_BCD: begin
        if (!req_q) req_d = 1'b1;
        else if (mem_ack) begin
          req_d = 1'b0;
          if (cnt_q == 4'd2) begin
            cnt_d   = 4'h0;
            state_d = S_FETCH_HI;
          end else cnt_d = cnt_q + 4'd1;
        end
      end

      S_STORE, S_LOAD: begin
        if (!req_q) req_d = 1'b1;
        else if (mem_ack) begin
          req_d = 1'b0;
          if (state_q == S_LOAD) begin
            v_we    = 1'b1;
            v_widx  = cnt_q;
            v_wdata = mem_rdata;
          end
          if (cnt_q == op_x) begin
            cnt_d   = 4'h0;
            state_d = S_FETCH_HI;
          end else cnt_d = cnt_q + 4'd1;
        end
      end

      default: ;
    endcase
  end

  // Memory address and write data follow the current state; both hold while a request waits.
  always_comb begin
    mem_addr  = pc_q;
    mem_wdata = 8'h00;
    case (state_q)
      S_FETCH_LO: mem_addr = pc_q + ADDR_W'(1);
      S_BCD: begin
        mem_addr  = i_q + ADDR_W'(cnt_q);
        mem_wdata = bcd_digit(vx_q, cnt_q[1:0]);
      end
      S_STORE: begin
        mem_addr  = i_q + ADDR_W'(cnt_q);
        mem_wdata = v_rf[cnt_q];
      end
      S_LOAD: mem_addr = i_q + ADDR_W'(cnt_q);
      default: ;
    endcase
  end

  chip8_timers #(
    .TICK_DIV(TICK_DIV)
  ) u_timers (
    .clk       (clk),
    .reset     (reset),
    .dt_we_i   (dt_we),
    .st_we_i   (st_we),
    .wdata_i   (vx_q),
    .dt_o      (dt_val),
    .sound_on_o(sound_on)
  );

  assign mem_req  = req_q;
  assign mem_we   = req_q && (state_q == S_BCD || state_q == S_STORE);
  assign halted   = (state_q == S_HALT);
  assign fault    = fault_q;
  assign debug_pc = pc_q;

endmodule

// File: tb/tb_chip8_core.sv
// tb_chip8_core: directed programs run against a byte memory model with a
// configurable ack delay; results are read back through memory stores.
module tb_chip8_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ack, halted, fault, sound_on;
  logic [11:0] mem_addr, debug_pc;
  logic [7:0]  mem_wdata, mem_rdata;

  logic [7:0]  mem [4096];
  logic [11:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];
  logic [11:0] rd_addr_q [$];
  logic [15:0] prog_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          req_cycles = 0;
  bit          rand_ack = 1'b0;

  always #5 clk = ~clk;

  chip8_core #(.TICK_DIV(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .halted   (halted),
    .fault    (fault),
    .sound_on (sound_on),
    .debug_pc (debug_pc)
  );

  // Memory responder: acks a pending request after 0..N cycles, one-cycle pulse.
  initial begin : responder
    int wait_cnt;
    int delay;
    wait_cnt  = 0;
    delay     = 0;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (mem_req) req_cycles++;
      if (!mem_req || reset) wait_cnt = 0;
      else if (wait_cnt >= delay) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          wr_addr_q.push_back(mem_addr);
          wr_data_q.push_back(mem_wdata);
        end else begin
          mem_rdata = mem[mem_addr];
          rd_addr_q.push_back(mem_addr);
        end
        wait_cnt = 0;
        delay    = rand_ack ? int'($urandom_range(5, 0)) : 0;
      end else wait_cnt++;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end else $display("  ok   %s = 'h%0h", tag, got);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Hold reset, clear memory and logs, place prog_q at 'h200.
  task automatic load_prog();
    reset = 1'b1;
    tick();
    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
    foreach (prog_q[k]) begin
      mem['h200 + 2 * k]     = prog_q[k][15:8];
      mem['h200 + 2 * k + 1] = prog_q[k][7:0];
    end
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    tick();
  endtask

  task automatic go();
    reset = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
    check_val(tag, 32'(halted), 32'd1);
  endtask

  function automatic logic [19:0] wr_at(input int k);
    if (k < wr_addr_q.size()) return {wr_addr_q[k], wr_data_q[k]};
    return 20'hFFFFF;
  endfunction

  function automatic logic [11:0] rd_at(input int k);
    if (k < rd_addr_q.size()) return rd_addr_q[k];
    return 12'hFFF;
  endfunction

  initial begin : main
    int n;
    logic [11:0] data_rd [$];

    // Reset state
    load_prog();
    check_val("rst_mem_req", 32'(mem_req), 32'd0);
    check_val("rst_pc", 32'(debug_pc), 32'h200);
    check_val("rst_halted", 32'(halted), 32'd0);
    check_val("rst_sound", 32'(sound_on), 32'd0);

    // T1: LD, ADD, EXIT
    prog_q = '{16'h6A05, 16'h7A03, 16'h00FD};
    load_prog(); go();
    wait_halt("t1_halted", 200);
    check_val("t1_pc", 32'(debug_pc), 32'h204);
    check_val("t1_fault", 32'(fault), 32'd0);

    // T1b: VA = 8 seen through BCD store
    prog_q = '{16'h6A05, 16'h7A03, 16'hA300, 16'hFA33, 16'h00FD};
    load_prog(); go();
    wait_halt("t1b_halted", 300);
    check_val("t1b_bcd", 32'({mem['h300], mem['h301], mem['h302]}), 32'h000008);

    // T2: CALL/RET, then RET on empty stack faults
    prog_q = '{16'h2300, 16'h00EE};
    load_prog();
    mem['h300] = 8'h00;
    mem['h301] = 8'hEE;
    go();
    wait_halt("t2_halted", 300);
    check_val("t2_fault", 32'(fault), 32'd1);
    check_val("t2_pc", 32'(debug_pc), 32'h202);
    check_val("t2_rd_cnt", 32'(rd_addr_q.size()), 32'd6);
    check_val("t2_rd_call", 32'(rd_at(2)), 32'h300);
    check_val("t2_rd_ret", 32'(rd_at(4)), 32'h202);
    req_cycles = 0;
    repeat (30) tick();
    check_val("t2_no_req", 32'(req_cycles), 32'd0);

    // T3: ALU flags, including the x == F case
    prog_q = '{16'h61FF, 16'h6202, 16'h8124, 16'hA400, 16'hFF55,
               16'h6307, 16'h6409, 16'h8345, 16'hA410, 16'hFF55,
               16'h6105, 16'h6205, 16'h8125, 16'hA420, 16'hFF55,
               16'h6F80, 16'h8FFE, 16'hA430, 16'hFF55, 16'h00FD};
    load_prog(); go();
    wait_halt("t3_halted", 2000);
    check_val("t3_add_v1", 32'(mem['h401]), 32'h01);
    check_val("t3_add_vf", 32'(mem['h40F]), 32'h01);
    check_val("t3_sub_v3", 32'(mem['h413]), 32'hFE);
    check_val("t3_sub_vf", 32'(mem['h41F]), 32'h00);
    check_val("t3_eq_v1", 32'(mem['h421]), 32'h00);
    check_val("t3_eq_vf", 32'(mem['h42F]), 32'h01);
    check_val("t3_shl_vf", 32'(mem['h43F]), 32'h01);

    // T4: BCD of 254, I unchanged afterwards
    prog_q = '{16'h63FE, 16'hA400, 16'hF333, 16'h6011, 16'hF055, 16'h00FD};
    load_prog(); go();
    wait_halt("t4_halted", 500);
    check_val("t4_wr_cnt", 32'(wr_addr_q.size()), 32'd4);
    check_val("t4_wr0", 32'(wr_at(0)), 32'h40002);
    check_val("t4_wr1", 32'(wr_at(1)), 32'h40105);
    check_val("t4_wr2", 32'(wr_at(2)), 32'h40204);
    check_val("t4_wr3", 32'(wr_at(3)), 32'h40011);

    // T5: block store/clear/load with random ack delay
    rand_ack = 1'b1;
    prog_q = '{16'h6001, 16'h6102, 16'h6203, 16'h6377, 16'hA500, 16'hF255,
               16'h6000, 16'h6100, 16'h6200, 16'hF265, 16'hA510, 16'hF355, 16'h00FD};
    load_prog(); go();
    wait_halt("t5_halted", 3000);
    rand_ack = 1'b0;
    check_val("t5_wr0", 32'(wr_at(0)), 32'h50001);
    check_val("t5_wr1", 32'(wr_at(1)), 32'h50102);
    check_val("t5_wr2", 32'(wr_at(2)), 32'h50203);
    foreach (rd_addr_q[k]) if (rd_addr_q[k] >= 12'h500) data_rd.push_back(rd_addr_q[k]);
    check_val("t5_rd_cnt", 32'(data_rd.size()), 32'd3);
    check_val("t5_rd_order", 32'(data_rd.size() == 3 ? {data_rd[0], data_rd[1], data_rd[2]} : 36'h0),
              32'(36'h500501502));
    check_val("t5_dump", 32'({mem['h510], mem['h511], mem['h512], mem['h513]}), 32'h01020377);

    // T6: sound timer loaded with 5 lasts 5 ticks of 4 cycles, keeps running in HALT
    prog_q = '{16'h6005, 16'hF018, 16'h00FD};
    load_prog(); go();
    n = 0;
    while (!sound_on && n < 200) begin tick(); n++; end
    check_val("t6_sound_rise", 32'(sound_on), 32'd1);
    n = 0;
    while (sound_on && n < 100) begin tick(); n++; end
    check_val("t6_sound_len", 32'(n >= 17 && n <= 20), 32'd1);
    check_val("t6_sound_off", 32'(sound_on), 32'd0);
    check_val("t6_halted", 32'(halted), 32'd1);

    // T6b: reset while a fetch is outstanding
    prog_q = '{16'h6005, 16'hF018, 16'h1204};
    load_prog(); go();
    n = 0;
    while (!(sound_on && mem_req) && n < 300) begin tick(); n++; end
    check_val("t6b_busy", 32'(sound_on && mem_req), 32'd1);
    reset = 1'b1;
    tick();
    check_val("t6b_req", 32'(mem_req), 32'd0);
    check_val("t6b_pc", 32'(debug_pc), 32'h200);
    check_val("t6b_sound", 32'(sound_on), 32'd0);
    rd_addr_q.delete();
    reset = 1'b0;
    repeat (10) tick();
    check_val("t6b_refetch", 32'(rd_at(0)), 32'h200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
